// File: rtl/lane_decrypt_seq.sv
// lane_decrypt_seq: inverse companion of the forward vector lane.
// Takes cipher elements tagged with the forward op select and recovers the plaintext through a
// two-stage valid/ready pipeline. Stage 1 registers the input. Stage 2 computes the inverse and
// registers the result.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   s_valid_i       input element valid
//   s_ready_o       block can accept an element this cycle
//   s_data_i        cipher element (forward data1)
//   s_operand_i     forward operand (data2); shifts use [SHW-1:0]
//   s_select_i      forward op select: [3:1] op, [0] variant
//   m_valid_o       output element valid
//   m_ready_i       downstream accepts the output
//   m_data_o        recovered element
//   m_last_o        output element is index VLEN-1 of its vector
//   m_err_o         output element's op was not invertible or illegal
//   err_sticky_o    set by any transferred erroneous element
//   clr_err_i       synchronous clear of err_sticky_o (a coincident set wins)
module lane_decrypt_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = 3,
  parameter int unsigned VLEN  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic [WIDTH-1:0] s_operand_i,
  input  logic [3:0]       s_select_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_last_o,
  output logic             m_err_o,
  output logic             err_sticky_o,
  input  logic             clr_err_i
);

  localparam int unsigned CntW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(VLEN - 1);

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic [WIDTH-1:0] s1_operand_q, s1_operand_d;
  logic [3:0]       s1_select_q, s1_select_d;

  // Stage 2 (output) registers
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_err_q, m_err_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_sticky_q, err_sticky_d;

  logic             s_xfer;
  logic             m_xfer;
  logic             s2_load;

  // Inverse datapath results
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] rot_r;
  logic [2*WIDTH-1:0] rot_l;
  logic [WIDTH-1:0]   inv_data;
  logic               inv_err;

  // Stage 2 can take a new value when it is empty or its content leaves this cycle.
  assign s2_load   = !m_valid_q || m_ready_i;
  assign s_ready_o = !s1_valid_q || !m_valid_q || m_ready_i;
  assign s_xfer    = s_valid_i && s_ready_o;
  assign m_xfer    = m_valid_q && m_ready_i;

  // Doubling the word makes rotation a plain shift of the concatenation.
  always_comb begin
    sh    = s1_operand_q[SHW-1:0];
    dbl   = {s1_data_q, s1_data_q};
    rot_r = dbl >> sh;
    rot_l = dbl << sh;
    inv_data = s1_data_q;
    inv_err  = 1'b0;
    case (s1_select_q[3:1])
      3'd0: inv_data = s1_select_q[0] ? (s1_data_q + s1_operand_q)
                                      : (s1_data_q - s1_operand_q);
      3'd1: inv_data = s1_data_q ^ s1_operand_q;
      3'd2: inv_data = s1_select_q[0] ? (s1_data_q << sh) : (s1_data_q >> sh);
      3'd3: inv_data = s1_select_q[0] ? rot_l[2*WIDTH-1:WIDTH] : rot_r[WIDTH-1:0];
      default: begin
        // Shift-and-with-key loses information; ops 5-7 do not exist.
        inv_data = s1_data_q;
        inv_err  = 1'b1;
      end
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_operand_d = s1_operand_q;
    s1_select_d  = s1_select_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_err_d      = m_err_q;
    cnt_d        = cnt_q;
    err_sticky_d = err_sticky_q;

    if (s_xfer) begin
      s1_valid_d   = 1'b1;
      s1_data_d    = s_data_i;
      s1_operand_d = s_operand_i;
      s1_select_d  = s_select_i;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_data_d = inv_data;
        m_err_d  = inv_err;
      end
    end

    if (m_xfer) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end

    if (m_xfer && m_err_q) begin
      err_sticky_d = 1'b1;
    end else if (clr_err_i) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_operand_q <= '0;
      s1_select_q  <= '0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_err_q      <= 1'b0;
      cnt_q        <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_operand_q <= s1_operand_d;
      s1_select_q  <= s1_select_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_err_q      <= m_err_d;
      cnt_q        <= cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign m_valid_o    = m_valid_q;
  assign m_data_o     = m_data_q;
  assign m_err_o      = m_err_q;
  assign m_last_o     = m_valid_q && (cnt_q == CntMax);
  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_lane_decrypt_seq.sv
// Bench for lane_decrypt_seq: stimulus pushes expected results into a queue, an independent
// monitor pops and compares on every output transfer and checks stall stability.
module tb_lane_decrypt_seq;

  localparam int VL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic [7:0] s_operand = '0;
  logic [3:0] s_select = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_err;
  logic       err_sticky;
  logic       clr_err = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_cnt = 0;
  bit   rand_bp = 0;
  bit   held_v = 0;
  logic [9:0] held_d;

  lane_decrypt_seq #(.WIDTH(8), .SHW(3), .VLEN(VL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .s_data_i     (s_data),
    .s_operand_i  (s_operand),
    .s_select_i   (s_select),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_last_o     (m_last),
    .m_err_o      (m_err),
    .err_sticky_o (err_sticky),
    .clr_err_i    (clr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: undo the forward lane operation with plain integer arithmetic.
  function automatic exp_t model(input logic [7:0] d, input logic [7:0] o, input logic [3:0] sel);
    int   di = d;
    int   oi = o;
    int   sh = oi % 8;
    int   r;
    exp_t x;
    x.err = 1'b0;
    case (sel[3:1])
      3'd0: r = sel[0] ? di + oi : di - oi;
      3'd1: r = di ^ oi;
      3'd2: r = sel[0] ? di << sh : di >> sh;
      3'd3: r = sel[0] ? ((di << sh) | (di >> (8 - sh))) : ((di >> sh) | (di << (8 - sh)));
      default: begin
        r     = di;
        x.err = 1'b1;
      end
    endcase
    x.data = 8'(r);
    return x;
  endfunction

  task automatic bp_tick();
    if (rand_bp) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one element from a falling edge; returns just before the accepting rising edge.
  task automatic send(input logic [7:0] d, input logic [7:0] o, input logic [3:0] sel);
    int guard = 0;
    @(negedge clk);
    bp_tick();
    s_valid = 1'b1;
    s_data = d;
    s_operand = o;
    s_select = sel;
    #1;
    while (!s_ready && guard < 1000) begin
      @(negedge clk);
      bp_tick();
      #1;
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_ready got 0, expected 1");
    end else begin
      exp_q.push_back(model(d, o, sel));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
    bp_tick();
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    rand_bp = 0;
    m_ready = 1'b1;
    s_valid = 1'b0;
    #3;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      #3;
      g++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    #3;
    check("drain_idle", m_valid, 0);
  endtask

  // Monitor: samples after the driver has settled for the cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (m_valid && !m_ready) begin
          if (held_v) check("stall_hold", {m_last, m_err, m_data}, held_d);
          held_v = 1;
          held_d = {m_last, m_err, m_data};
        end else begin
          held_v = 0;
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %0h, expected no output", m_data);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e.data);
            check("m_err", m_err, e.err);
            check("m_last", m_last, (mon_cnt == VL - 1));
            mon_cnt = (mon_cnt + 1) % VL;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : main
    int n_acc;
    int k;
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_err", m_err, 0);
    check("rst_err_sticky", err_sticky, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;

    // Back-to-back xor stream: last flags on the 4th and 8th outputs.
    for (int i = 0; i < 8; i++) send(8'(i), 8'hFF, 4'b0010);
    idle();
    drain();

    // Two-cycle latency for an inverse add.
    send(8'h05, 8'h10, 4'b0000);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check("lat_not_yet", m_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid", m_valid, 1);
    check("lat_data", m_data, 8'hF5);
    check("lat_err", m_err, 0);
    drain();

    // Rotations including a zero shift.
    send(8'hA1, 8'h03, 4'b0110);
    send(8'h5A, 8'h00, 4'b0110);
    idle();
    drain();

    // Backpressure: only two elements fit while the output stalls.
    m_ready = 1'b0;
    n_acc = 0;
    k = 0;
    repeat (5) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data = 8'(8'h20 + k);
      s_operand = 8'h0F;
      s_select = 4'b0010;
      #1;
      if (s_ready) begin
        exp_q.push_back(model(s_data, s_operand, s_select));
        n_acc++;
        k++;
      end
    end
    check("bp_accepted", n_acc, 2);
    check("bp_ready_low", s_ready, 0);
    drain();

    // Error path and sticky flag.
    check("sticky_clear_before", err_sticky, 0);
    send(8'h33, 8'h00, 4'b1000);
    send(8'h44, 8'h00, 4'b1100);
    send(8'h55, 8'h0F, 4'b0010);
    idle();
    drain();
    check("sticky_set", err_sticky, 1);

    // Clear coinciding with an erroneous transfer: the set wins.
    m_ready = 1'b0;
    send(8'h66, 8'h00, 4'b1010);
    idle();
    @(negedge clk);
    clr_err = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #3;
    check("sticky_set_wins", err_sticky, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    #1;
    check("sticky_cleared", err_sticky, 0);
    drain();

    // Randomized traffic with random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      send(8'($urandom), 8'($urandom), 4'($urandom));
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    drain();

    // Asynchronous reset with two elements in flight.
    m_ready = 1'b0;
    send(8'h11, 8'h01, 4'b0010);
    send(8'h22, 8'h01, 4'b0010);
    idle();
    @(negedge clk);
    #3;
    check("inflight_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_sticky", err_sticky, 0);
    exp_q.delete();
    mon_cnt = 0;
    held_v = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    #3;
    check("post_rst_empty", m_valid, 0);
    for (int i = 0; i < 4; i++) send(8'(8'h80 + i), 8'h3C, 4'b0011);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lane_decrypt_seq.md
Name: lane_decrypt_seq

Overview:
- Inverse-direction companion of the vector lane. Takes a stream of 8-bit cipher elements tagged with the same op select the encrypting lane used, and recovers the plaintext elements.
- Two-stage pipelined datapath with valid/ready on both sides.
- Keeps a per-vector element counter to mark the last element, plus a sticky error flag for non-invertible or illegal ops.
- Sits between the vector register read port and the writeback path of the decrypt pipeline.

Parameters:
- WIDTH, 8, element width in bits.
- SHW, 3, shift-amount width (log2 WIDTH).
- VLEN, 4, elements per vector; sets the m_last period.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  block can accept an element this cycle.
- s_data  in  WIDTH  cipher element (data1 of the forward lane).
- s_operand  in  WIDTH  operand used by the forward lane (data2); shifts use bits [SHW-1:0].
- s_select  in  4  forward op select: [3:1] op, [0] variant.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts the output.
- m_data  out  WIDTH  recovered element.
- m_last  out  1  output element is index VLEN-1 of its vector.
- m_err  out  1  output element's op was not invertible or illegal.
- err_sticky  out  1  set by any accepted erroneous element.
- clr_err  in  1  synchronous clear of err_sticky.

Behaviour:
- Reset (async, rst_n=0): both stage valids 0, m_valid=0, m_data=0, m_last=0, m_err=0, err_sticky=0, element counter=0.
- Handshakes:
  - An input transfer occurs when s_valid&&s_ready.
  - An output transfer occurs when m_valid&&m_ready.
  - s_ready = !s1_valid || !s2_valid || m_ready. It is combinational from m_ready; there is no combinational path from s_valid.
  - Stage 1 registers s_data, s_operand and s_select. Stage 2 computes and registers the result.
- Latency: an accepted element appears on m_* 2 cycles later when unstalled. Throughput is 1 element/cycle.
- Stalls:
  - When m_valid && !m_ready, stage 2 holds m_data, m_last and m_err stable.
  - Stage 1 fills if it is empty, then s_ready drops.
  - No element is lost or duplicated.
- Inverse ops, with sh = s_operand[SHW-1:0] and all arithmetic mod 2^WIDTH:
  - op 0, variant 0 (forward add): m_data = data - operand.
  - op 0, variant 1 (forward sub): m_data = data + operand.
  - op 1 (xor): m_data = data ^ operand. Variant bit is ignored.
  - op 2 (linear shift): shift in the opposite direction of the forward variant, zero fill. Variant 0 means forward left, so the inverse is a logical right shift by sh; variant 1 is the reverse. Lost bits stay 0; m_err=0.
  - op 3 (circular shift): rotate opposite to the forward variant by sh. sh=0 passes data unchanged.
  - op 4 (shift-and with key): not invertible. m_data = data, m_err=1.
  - ops 5–7: illegal. m_data = data, m_err=1.
- Element counter:
  - Increments on each output transfer and wraps VLEN-1 → 0.
  - m_last = (counter == VLEN-1) && m_valid.
  - Erroneous elements still count.
- err_sticky:
  - Set in the cycle after an output transfer with m_err=1.
  - clr_err clears it. If a set and a clear coincide, the set wins.
- Reset mid-stream discards all in-flight elements and restarts the counter at 0.

Test Plan:
- Round trip, op 0 variant 0: data=0x05, operand=0x10, m_ready=1 → m_data=0xF5 two cycles after acceptance; m_err=0.
- Round trip, op 3 variant 0: data=0xA1, sh=3 → m_data=0x34 (rotate right by 3). Also sh=0, data=0x5A → m_data=0x5A.
- Stream 8 back-to-back xor elements with operand 0xFF, data 0..7 → outputs 0xFF..0xF8 in order. m_last is high on the 4th and 8th outputs.
- Backpressure: hold m_ready=0 for 5 cycles mid-stream → s_ready drops after 2 elements are buffered, m_data stays stable, and after release all elements emerge in order with none dropped.
- Error path: send op 4, then op 6, then a legal op 1 → first two outputs have m_err=1 and m_data=data, and err_sticky=1. Asserting clr_err in the same cycle as a new error transfer leaves err_sticky=1; clr_err alone later clears it.
- Assert rst_n=0 asynchronously with 2 elements in flight → m_valid=0 immediately. After release, the next vector's 4th output carries m_last.
